// File: rtl/mux4_arb_pkg.sv
// Shared types and sizes for the 4-way round-robin arbiter and its datapath mux.
package mux4_arb_pkg;

  localparam int NREQ   = 4;
  localparam int SEL_W  = 2;
  localparam int DATA_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  function automatic logic [NREQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux4to1.sv
// Plain 4:1 data mux shared by the requesters; purely combinational.
module mux4to1
  import mux4_arb_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] d,
  input  logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    unique case (sel)
      2'd0:    y = a;
      2'd1:    y = b;
      2'd2:    y = c;
      default: y = d;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning a shared 4:1 datapath. Defining ARB_TIMEOUT_EN adds a
// hold counter that preempts an owner after MAX_HOLD grant cycles if others wait.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] d,
  output logic [NREQ-1:0]   gnt,
  output logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] y,
  output logic              valid
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("MAX_HOLD must be in 1..255");
  end

  arb_state_e       r_state, w_next_state;
  logic [NREQ-1:0]  r_gnt, w_next_gnt;
  logic [SEL_W-1:0] r_sel, w_next_sel;
  logic [SEL_W-1:0] r_ptr, w_next_ptr;

  logic [NREQ-1:0]  w_cand;
  logic [SEL_W-1:0] w_win;
  logic             w_found;
  logic             w_owner_req;
  logic             w_expired;
  logic             w_new_grant;

  // The owner is never its own successor: on release its req bit is already low,
  // and on preemption it must be skipped, so masking with the grant covers both.
  assign w_cand      = req & ~r_gnt;
  assign w_owner_req = |(req & r_gnt);

  // NOTE: every variable driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    // Scan farthest-first so the nearest candidate after ptr is assigned last.
    for (int k = NREQ; k >= 1; k--) begin
      if (w_cand[r_ptr + SEL_W'(k)]) begin
        w_found = 1'b1;
        w_win   = r_ptr + SEL_W'(k);
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_hold;

  // r_hold counts completed grant cycles before the current one, so the
  // MAX_HOLD-th cycle of ownership is the last before a possible preemption.
  assign w_expired = (r_hold >= 8'(MAX_HOLD - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold <= '0;
    end else if (w_new_grant) begin
      r_hold <= '0;
    end else if (r_state == GRANT && !w_expired) begin
      r_hold <= r_hold + 8'd1;
    end
  end
`else
  assign w_expired = 1'b0;
`endif

  always_comb begin
    w_next_state = r_state;
    w_next_gnt   = r_gnt;
    w_next_sel   = r_sel;
    w_next_ptr   = r_ptr;
    w_new_grant  = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_new_grant = w_found;
      end
      GRANT: begin
        if (!w_owner_req) begin
          w_new_grant = w_found;
          if (!w_found) begin
            w_next_state = IDLE;
            w_next_gnt   = '0;
          end
        end else begin
          w_new_grant = w_expired && w_found;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_gnt   = '0;
      end
    endcase

    if (w_new_grant) begin
      w_next_state = GRANT;
      w_next_gnt   = idx_to_onehot(w_win);
      w_next_sel   = w_win;
      w_next_ptr   = w_win;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of the order the statements execute in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_ptr   <= SEL_W'(NREQ - 1);
    end else begin
      r_state <= w_next_state;
      r_gnt   <= w_next_gnt;
      r_sel   <= w_next_sel;
      r_ptr   <= w_next_ptr;
    end
  end

  mux4to1 u_mux (
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .sel (r_sel),
    .y   (y)
  );

  assign gnt   = r_gnt;
  assign sel   = r_sel;
  assign valid = |r_gnt;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios plus a long random
// run, all compared against a transaction-level round-robin reference model.
module tb_mux4_rr_arbiter;
  import mux4_arb_pkg::*;

  localparam int TB_MAX_HOLD = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [DATA_W-1:0] a, b, c, d;
  logic [NREQ-1:0]   gnt;
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] y;
  logic              valid;

  mux4_rr_arbiter #(.MAX_HOLD(TB_MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .gnt   (gnt),
    .sel   (sel),
    .y     (y),
    .valid (valid)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_bad = 0;
  string phase = "init";

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %0h expected %0h (t=%0t)", phase, tag, act, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, the last owner, and how long it has held.
  int m_owner  = -1;
  int m_ptr    = 3;
  int m_sel    = 0;
  int m_cycles = 0;

  function automatic logic [DATA_W-1:0] datum(input int i);
    case (i)
      0:       return a;
      1:       return b;
      2:       return c;
      default: return d;
    endcase
  endfunction

  function automatic int rr_pick(input logic [3:0] r, input int from, input int skip);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (from + k) % 4;
      if (r[i] && i != skip) return i;
    end
    return -1;
  endfunction

  task automatic give(input int w);
    m_owner  = w;
    m_ptr    = w;
    m_sel    = w;
    m_cycles = 1;
  endtask

  task automatic model_edge(input logic rst, input logic [3:0] r);
    int w;
    if (!rst) begin
      m_owner  = -1;
      m_sel    = 0;
      m_ptr    = 3;
      m_cycles = 0;
    end else if (m_owner < 0) begin
      w = rr_pick(r, m_ptr, -1);
      if (w >= 0) give(w);
    end else if (!r[m_owner]) begin
      w = rr_pick(r, m_ptr, -1);
      if (w >= 0) give(w);
      else m_owner = -1;
    end else begin
`ifdef ARB_TIMEOUT_EN
      w = (m_cycles >= TB_MAX_HOLD) ? rr_pick(r, m_ptr, m_owner) : -1;
      if (w >= 0) give(w);
      else m_cycles++;
`else
      m_cycles++;
`endif
    end
  endtask

  task automatic compare_model();
    logic [3:0] eg;
    eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    check("gnt", gnt, eg);
    check("sel", sel, m_sel);
    check("valid", valid, m_owner >= 0);
    check("y", y, datum(m_sel));
    check("onehot0", $onehot0(gnt), 1);
  endtask

  // One clock: apply req, let the edge happen, advance the model, compare.
  task automatic step(input logic [3:0] r);
    req = r;
    @(posedge clk);
    model_edge(rst_n, r);
    #1;
    compare_model();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         order[$];
    logic [3:0] ys[$];
    int         exp_order[5];
    logic [3:0] exp_y[5];
    logic [3:0] prev_g;
    logic [3:0] r;
    int         vcnt;
    int         starve[4];
    int         max_starve;

    exp_order = '{0, 1, 2, 3, 0};
    exp_y     = '{4'd5, 4'd1, 4'd5, 4'd9, 4'd5};

    rst_n = 1'b0;
    req   = 4'b1111;
    a = 4'd5; b = 4'd1; c = 4'd5; d = 4'd9;
    #7;

    // Reset, then the first grant goes to requester 0.
    phase = "reset";
    step(4'b1111);
    check("rst_gnt", gnt, 4'b0000);
    check("rst_y_is_a", y, a);
    rst_n = 1'b1;
    step(4'b1111);
    check("first_gnt", gnt, 4'b0001);
    check("first_y", y, 4'd5);

    // Full contention, each owner releases after two grant cycles.
    phase = "rr_order";
    rst_n = 1'b0;
    step(4'b1111);
    rst_n  = 1'b1;
    prev_g = '0;
    for (int cyc = 0; cyc < 12 && order.size() < 5; cyc++) begin
      r = 4'b1111;
      if (m_owner >= 0 && m_cycles >= 2) r[m_owner] = 1'b0;
      step(r);
      check("no_bubble", valid, 1);
      if (valid && gnt != prev_g) begin
        order.push_back(int'(sel));
        ys.push_back(y);
      end
      prev_g = gnt;
    end
    check("order_len", order.size(), 5);
    for (int i = 0; i < order.size() && i < 5; i++) begin
      check($sformatf("order%0d", i), order[i], exp_order[i]);
      check($sformatf("yseq%0d", i), ys[i], exp_y[i]);
    end

    // Lone requester 2 for three cycles, then idle with sel parked at 2.
    phase = "pulse2";
    rst_n = 1'b0;
    step(4'b0000);
    rst_n = 1'b1;
    step(4'b0000);
    vcnt = 0;
    step(4'b0100);
    check("gnt_after_1", gnt, 4'b0100);
    vcnt += valid;
    step(4'b0100);
    vcnt += valid;
    step(4'b0100);
    vcnt += valid;
    step(4'b0000);
    vcnt += valid;
    check("idle_gnt", gnt, 4'b0000);
    check("idle_sel", sel, 2);
    step(4'b0000);
    vcnt += valid;
    check("sel_parked", sel, 2);
    check("valid_cycles", vcnt, 3);

    // Reset in the middle of owner 2's grant.
    phase = "mid_reset";
    step(4'b0100);
    step(4'b0100);
    check("owner2", gnt, 4'b0100);
    rst_n = 1'b0;
    step(4'b0101);
    check("rst_gnt", gnt, 4'b0000);
    check("rst_sel", sel, 0);
    check("rst_valid", valid, 0);
    rst_n = 1'b1;
    step(4'b0101);
    check("post_rst_gnt", gnt, 4'b0001);

`ifdef ARB_TIMEOUT_EN
    // Owner 1 holds forever; requester 3 arrives and takes over after MAX_HOLD.
    phase = "timeout";
    rst_n = 1'b0;
    step(4'b0000);
    rst_n = 1'b1;
    step(4'b0010);
    vcnt = 1;
    step(4'b0010);
    if (gnt == 4'b0010) vcnt++;
    for (int i = 0; i < 8 && gnt == 4'b0010; i++) begin
      step(4'b1010);
      if (gnt == 4'b0010) vcnt++;
    end
    check("hold_cycles", vcnt, TB_MAX_HOLD);
    check("switch_to3", gnt, 4'b1000);
    phase = "no_rival";
    rst_n = 1'b0;
    step(4'b0000);
    rst_n = 1'b1;
    vcnt  = 0;
    for (int i = 0; i < 20; i++) begin
      step(4'b0010);
      if (gnt == 4'b0010) vcnt++;
    end
    check("hold_forever", vcnt, 20);
`endif

    // Long random run with sticky requests and changing data.
    phase = "random";
    rst_n = 1'b0;
    step(4'b0000);
    rst_n      = 1'b1;
    r          = '0;
    prev_g     = '0;
    starve     = '{0, 0, 0, 0};
    max_starve = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(3) == 0) r[i] = ~r[i];
      {a, b, c, d} = 16'($urandom);
      step(r);
      for (int i = 0; i < 4; i++) begin
        if (!r[i] || gnt[i]) starve[i] = 0;
        else if (valid && gnt != prev_g) starve[i]++;
        if (starve[i] > max_starve) max_starve = starve[i];
      end
      prev_g = gnt;
    end
    check("max_starve_le3", max_starve <= 3, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, 8, maximum consecutive grant cycles before preemption (used only when ARB_TIMEOUT_EN is defined; legal range 1..255).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset; synchronous, active-low.
REQ-004 Port: req  input  4  request from requesters 0..3; held high until the requester is done.
REQ-005 Port: a, b, c, d  input  4 each  data from requesters 0, 1, 2, 3 respectively.
REQ-006 Port: gnt  output  4  one-hot grant (all zero when idle); registered.
REQ-007 Port: sel  output  2  binary index of current or last owner; registered.
REQ-008 Port: y  output  4  shared datapath output: a/b/c/d selected by sel; combinational from sel and data.
REQ-009 Port: valid  output  1  high when gnt is non-zero, i.e. y carries an owner's data.

Function
REQ-010 States SHALL be IDLE and GRANT.
REQ-011 IDLE with req==0: remain IDLE; gnt=0, valid=0, sel holds its previous value.
REQ-012 IDLE with any req bit set: the next edge SHALL enter GRANT with gnt set to the round-robin winner (1-cycle latency from req to gnt).
REQ-013 Round-robin winner: first set req bit searched from (ptr+1) mod 4 upward with wrap 3->0, where ptr is the last owner index.
REQ-014 On every grant, ptr and sel SHALL load the winner's index on the same edge as gnt.
REQ-015 GRANT while req[owner]==1: hold gnt and sel unchanged (subject to REQ-022).
REQ-016 GRANT when req[owner] drops with other req bits set: the next edge SHALL grant the next round-robin winner directly (no idle bubble).
REQ-017 GRANT when req[owner] drops and no other req is set: the next edge SHALL return to IDLE with gnt=0.
REQ-018 A dropped owner that re-raises req on the same cycle it is released SHALL be treated as a new request with lowest priority (ptr already points to it).
REQ-019 gnt SHALL never have more than one bit set; valid SHALL equal |gnt.
REQ-020 Requests raised by non-owners during GRANT SHALL NOT disturb the current grant.

Reset
REQ-021 When rst_n==0 at a rising edge: state=IDLE, gnt=0, sel=0, ptr=3 (requester 0 has top priority after reset), hold counter=0; this overrides any grant in progress, and y then shows a.

Configuration
REQ-022 With ARB_TIMEOUT_EN defined: a hold counter SHALL count cycles in GRANT for the current owner; after MAX_HOLD cycles, if any other req bit is set, the next edge SHALL grant the next round-robin winner excluding the current owner; if no other req is pending, the grant SHALL continue and the counter SHALL saturate; the counter SHALL clear on every new grant.
REQ-023 Without ARB_TIMEOUT_EN: no counter logic SHALL be synthesized, MAX_HOLD SHALL be ignored, and the owner SHALL hold the grant until it drops req.

Structure
REQ-024 Shared package mux4_arb_pkg SHALL hold the state enum (IDLE, GRANT), NREQ=4, SEL_W=2 and DATA_W=4.
REQ-025 Datapath SHALL be the team's existing mux4to1 instantiated as the one sub-module (a,b,c,d,sel -> y); the arbitration logic and the round-robin search SHALL reside in mux4_rr_arbiter.

Verification
REQ-026 Reset with req=4'b1111 -> first grant after reset gnt=4'b0001, sel=0, y=a.
REQ-027 a=5,b=1,c=5,d=9; req=4'b1111 held with each owner dropping req after 2 cycles -> grant order 0,1,2,3,0 with no idle cycles; y sequence 5,1,5,9.
REQ-028 Only req[2] pulsed for 3 cycles -> gnt=4'b0100 one cycle after req rises, valid high for 3 cycles, then IDLE with gnt=0 and sel staying at 2.
REQ-029 ARB_TIMEOUT_EN with MAX_HOLD=4: req[1] held forever and req[3] raised at cycle 2 -> owner switches to 3 after 4 grant cycles; with req[3] absent, owner 1 keeps the grant indefinitely.
REQ-030 rst_n driven low for 1 cycle mid-grant of owner 2 -> next cycle gnt=0, sel=0, valid=0; the next grant follows the post-reset priority order (0 first).
REQ-031 Random req for 10k cycles -> gnt always one-hot or zero, no requester starved beyond 3 other grants, y==data[sel] whenever valid.
